battleship_board_ctrl: RTL and testbench
========================================

Name: battleship_board_ctrl

Overview:
- Parametrised single-player board engine for the battleship game: one instance per side (player, PC).
- Owns a BOARD_N x BOARD_N cell array, performs validated multi-cell ship placement (horizontal/vertical, bounds and overlap checks) and attack resolution through a valid/ready command port with a registered response.
- Tracks remaining ship cells and asserts all_sunk.
- Exposes a combinational cell read port for the VGA renderer and game FSM.

Parameters:
- BOARD_N, 5, board side length in cells (2..15).
- MAX_SHIPS, 4, maximum number of ships accepted.
- MAX_LEN, 3, maximum ship length in cells (1..BOARD_N).
- Derived localparams:
  - CW = $clog2(BOARD_N) coordinate width.
  - LW = $clog2(MAX_LEN+1).
  - SW = $clog2(MAX_SHIPS+1).
  - KW = $clog2(MAX_SHIPS*MAX_LEN+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous board clear, same effect as reset.
- lock  in  1  0 = placement phase, 1 = attack phase.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE with no response pending.
- cmd_attack  in  1  0 = place, 1 = attack.
- cmd_row  in  CW  row (placement origin or attack target).
- cmd_col  in  CW  column.
- cmd_len  in  LW  ship length (place only).
- cmd_vert  in  1  1 = ship extends along +row, 0 = along +col.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_code  out  3  result code, valid with rsp_valid.
- ships_placed  out  SW  accepted ships.
- cells_left  out  KW  unhit ship cells.
- all_sunk  out  1  high when ships_placed>0 and cells_left==0.
- rd_row  in  CW  read address row.
- rd_col  in  CW  read address column.
- rd_cell  out  2  combinational cell value, 00 if address out of range.

Behaviour:
- Cell encoding:
  - 00 WATER.
  - 01 SHIP.
  - 10 HIT (ship cell attacked).
  - 11 MISS (water cell attacked).
- rsp_code values:
  - 0 PLACE_OK.
  - 1 ERR_BOUNDS.
  - 2 ERR_OVERLAP.
  - 3 ERR_FULL.
  - 4 ATK_MISS.
  - 5 ATK_HIT.
  - 6 ATK_REPEAT.
  - 7 ERR_LOCKED.
- Reset (rst low) or clr high:
  - All cells WATER.
  - FSM to IDLE; any in-flight command is aborted and produces no response.
  - ships_placed=0, cells_left=0, rsp_valid=0, rsp_code=0, all_sunk=0.
  - cmd_ready=1 from the first cycle after release.
- Handshake:
  - Command accepted on a rising edge with cmd_valid && cmd_ready; fields captured at that edge.
  - Exactly one rsp_valid pulse per accepted command.
  - cmd_ready stays low until the cycle after rsp_valid.
- FSM states: IDLE, CHECK, WRITE, RESP.
- IDLE, on accepting a place command:
  - lock=1 -> RESP with ERR_LOCKED.
  - cmd_len==0, cmd_len>MAX_LEN, cmd_row>=BOARD_N, cmd_col>=BOARD_N, or end cell (origin + len - 1 along the axis) >= BOARD_N -> RESP with ERR_BOUNDS. End-cell arithmetic is done at CW+1 bits so wrap cannot occur.
  - ships_placed==MAX_SHIPS -> RESP with ERR_FULL.
  - Error priority: LOCKED > BOUNDS > FULL.
  - Otherwise -> CHECK.
- CHECK:
  - Visits one cell per cycle, index k = 0..len-1.
  - Any non-WATER cell -> RESP with ERR_OVERLAP; board unchanged.
  - After k = len-1 -> WRITE.
- WRITE:
  - Writes SHIP to one cell per cycle.
  - After the last cell -> RESP with PLACE_OK.
  - ships_placed increments by 1 and cells_left by len, both on the final write edge.
- IDLE, on accepting an attack command:
  - lock=0 -> ERR_LOCKED.
  - Out-of-range coordinate -> ERR_BOUNDS.
  - SHIP cell -> cell becomes HIT, cells_left decrements, ATK_HIT.
  - WATER cell -> cell becomes MISS, ATK_MISS.
  - HIT or MISS cell -> ATK_REPEAT, no change.
  - Cell update on the accept edge; state goes to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
- Latency from accept edge to rsp_valid:
  - Attacks and immediate errors: 1 cycle.
  - ERR_OVERLAP: k+2, where k is the first occupied index.
  - PLACE_OK: 2*len+1.
- all_sunk is registered and updates the cycle after cells_left reaches 0. It stays high until reset or clr.
- Attacks after all_sunk are still processed and return MISS or REPEAT.
- lock changing mid-placement does not abort the operation; lock is sampled only at accept.
- clr has priority over any command on the same edge.

Optional Feature:
- Macro SUNK_REPORT_EN.
- When defined:
  - Each cell additionally stores a ship id (SW bits).
  - A per-ship remaining-length counter is kept.
  - Extra outputs: sunk_pulse (1 bit) and sunk_id (SW bits).
  - When an ATK_HIT reduces a ship's counter to 0, sunk_pulse=1 with sunk_id = that ship's index, coincident with rsp_valid.
- When undefined:
  - No id storage; sunk_pulse and sunk_id ports are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, lock=0, place (1,1) len3 horizontal -> cmd_ready falls; rsp_valid 7 cycles after accept with code 0; cells (1,1),(1,2),(1,3)=01; ships_placed=1; cells_left=3.
- Place (0,2) len3 vertical over that ship -> code 2 with rsp_valid 3 cycles after accept (overlap at k=1); board and counters unchanged.
- BOARD_N=5: place (4,3) len3 horizontal -> code 1 after 1 cycle. Same command with lock=1 -> code 7.
- Fill MAX_SHIPS=4 ships, then a 5th legal placement -> code 3.
- lock=1, attack (1,1),(1,2),(1,3) -> code 5 each; cells_left 3->0; all_sunk=1 the cycle after. Re-attack (1,1) -> code 6. Attack (0,0) -> code 4, cell=11.
- Assert clr, and separately rst, during WRITE of a len3 ship -> no rsp_valid; all cells 00; counters 0; cmd_ready=1 next cycle. With SUNK_REPORT_EN: sinking ship 0 -> sunk_pulse=1, sunk_id=0.

Source files
------------

// File: rtl/battleship_board_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : battleship_board_ctrl
//  Purpose  : Single-side battleship board engine. Owns a BOARD_N x BOARD_N
//             cell array. It validates and places multi-cell ships (one cell
//             checked or written per cycle) and resolves attacks in one cycle.
//             Commands use a valid/ready port, and every accepted command
//             produces one registered response strobe.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst          clock (rising edge), asynchronous active-low reset
//    clr               synchronous clear, same effect as reset
//    lock              0 = placement phase, 1 = attack phase
//    cmd_*             command request (valid/ready, place or attack)
//    rsp_valid/code    one-cycle response strobe and result code
//    ships_placed      number of accepted ships
//    cells_left        number of unhit ship cells
//    all_sunk          sticky flag, set once every placed ship cell is hit
//    rd_row/col/cell   combinational cell read port (00 when out of range)
//  Optional build macro
//    SUNK_REPORT_EN    adds per-cell ship ids and per-ship remaining counters;
//                      exposes sunk_pulse / sunk_id, which are coincident with
//                      the response of the hit that sinks a ship
// ============================================================================
module battleship_board_ctrl #(
    parameter  int BOARD_N   = 5,
    parameter  int MAX_SHIPS = 4,
    parameter  int MAX_LEN   = 3,
    localparam int CW        = $clog2(BOARD_N),
    localparam int LW        = $clog2(MAX_LEN + 1),
    localparam int SW        = $clog2(MAX_SHIPS + 1),
    localparam int KW        = $clog2(MAX_SHIPS * MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          lock,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_attack,
    input  logic [CW-1:0] cmd_row,
    input  logic [CW-1:0] cmd_col,
    input  logic [LW-1:0] cmd_len,
    input  logic          cmd_vert,
    output logic          rsp_valid,
    output logic [2:0]    rsp_code,
    output logic [SW-1:0] ships_placed,
    output logic [KW-1:0] cells_left,
    output logic          all_sunk,
`ifdef SUNK_REPORT_EN
    output logic          sunk_pulse,
    output logic [SW-1:0] sunk_id,
`endif
    input  logic [CW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output logic [1:0]    rd_cell
);

    localparam int NCELL = BOARD_N * BOARD_N;

    // Coordinates are widened by one bit so that origin + len - 1 cannot wrap.
    typedef logic [CW:0]   cext_t;
    typedef logic [LW-1:0] len_t;
    typedef logic [SW-1:0] ship_t;
    typedef logic [KW-1:0] cnt_t;

    localparam cext_t N_EXT       = cext_t'(BOARD_N);
    localparam len_t  MAX_LEN_L   = len_t'(MAX_LEN);
    localparam ship_t MAX_SHIPS_S = ship_t'(MAX_SHIPS);

    localparam logic [1:0] CELL_WATER = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_HIT   = 2'b10;
    localparam logic [1:0] CELL_MISS  = 2'b11;

    localparam logic [2:0] RSP_PLACE_OK    = 3'd0;
    localparam logic [2:0] RSP_ERR_BOUNDS  = 3'd1;
    localparam logic [2:0] RSP_ERR_OVERLAP = 3'd2;
    localparam logic [2:0] RSP_ERR_FULL    = 3'd3;
    localparam logic [2:0] RSP_ATK_MISS    = 3'd4;
    localparam logic [2:0] RSP_ATK_HIT     = 3'd5;
    localparam logic [2:0] RSP_ATK_REPEAT  = 3'd6;
    localparam logic [2:0] RSP_ERR_LOCKED  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       row_q, row_d;
    logic [CW-1:0]       col_q, col_d;
    len_t                len_q, len_d;
    logic                vert_q, vert_d;
    len_t                k_q, k_d;
    logic [2:0]          code_q, code_d;
    ship_t               ships_q, ships_d;
    cnt_t                left_q, left_d;
    logic                sunk_all_q, sunk_all_d;
    logic [2*NCELL-1:0]  board_q, board_d;

`ifdef SUNK_REPORT_EN
    logic [SW*NCELL-1:0]    id_q, id_d;
    logic [LW*MAX_SHIPS-1:0] rem_q, rem_d;
    logic                   sunk_pulse_q, sunk_pulse_d;
    ship_t                  sunk_id_q, sunk_id_d;
    ship_t                  hit_id;
    len_t                   hit_rem;
`endif

    // Address helpers: current CHECK/WRITE cell, accepted attack cell, read port.
    cext_t      k_ext, cur_row, cur_col, end_ext;
    int         cur_idx, acc_idx, rd_idx;
    logic [1:0] cur_cell, acc_cell;
    logic       acc_in_range, place_bad_bounds;

    always_comb begin
        k_ext    = cext_t'(k_q);
        cur_row  = cext_t'(row_q) + (vert_q ? k_ext : cext_t'(0));
        cur_col  = cext_t'(col_q) + (vert_q ? cext_t'(0) : k_ext);
        cur_idx  = int'(cur_row) * BOARD_N + int'(cur_col);
        cur_cell = board_q[2*cur_idx +: 2];

        acc_in_range = (cext_t'(cmd_row) < N_EXT) && (cext_t'(cmd_col) < N_EXT);
        acc_idx      = int'(cmd_row) * BOARD_N + int'(cmd_col);
        acc_cell     = board_q[2*acc_idx +: 2];

        // Last cell along the ship axis. A zero length makes this value
        // meaningless, but a zero length is rejected on its own.
        end_ext = (cmd_vert ? cext_t'(cmd_row) : cext_t'(cmd_col))
                + cext_t'(cmd_len) - cext_t'(1);
        place_bad_bounds = (cmd_len == len_t'(0)) || (cmd_len > MAX_LEN_L)
                         || !acc_in_range || (end_ext >= N_EXT);

        rd_idx  = int'(rd_row) * BOARD_N + int'(rd_col);
        rd_cell = CELL_WATER;
        if ((cext_t'(rd_row) < N_EXT) && (cext_t'(rd_col) < N_EXT)) begin
            rd_cell = board_q[2*rd_idx +: 2];
        end

`ifdef SUNK_REPORT_EN
        hit_id  = id_q[SW*acc_idx +: SW];
        hit_rem = rem_q[LW*int'(hit_id) +: LW];
`endif
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        len_d   = len_q;
        vert_d  = vert_q;
        k_d     = k_q;
        code_d  = code_q;
        ships_d = ships_q;
        left_d  = left_q;
        board_d = board_q;
        // The flag looks at registered counters, so it rises the cycle after
        // cells_left reaches zero and stays set until reset or clear.
        sunk_all_d = sunk_all_q | ((ships_q != ship_t'(0)) && (left_q == cnt_t'(0)));
`ifdef SUNK_REPORT_EN
        id_d         = id_q;
        rem_d        = rem_q;
        sunk_pulse_d = 1'b0;
        sunk_id_d    = sunk_id_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_RESP;
                    if (!cmd_attack) begin
                        row_d  = cmd_row;
                        col_d  = cmd_col;
                        len_d  = cmd_len;
                        vert_d = cmd_vert;
                        k_d    = len_t'(0);
                        if (lock) begin
                            code_d = RSP_ERR_LOCKED;
                        end else if (place_bad_bounds) begin
                            code_d = RSP_ERR_BOUNDS;
                        end else if (ships_q == MAX_SHIPS_S) begin
                            code_d = RSP_ERR_FULL;
                        end else begin
                            state_d = S_CHECK;
                        end
                    end else begin
                        if (!lock) begin
                            code_d = RSP_ERR_LOCKED;
                        end else if (!acc_in_range) begin
                            code_d = RSP_ERR_BOUNDS;
                        end else begin
                            case (acc_cell)
                                CELL_SHIP: begin
                                    board_d[2*acc_idx +: 2] = CELL_HIT;
                                    left_d = left_q - cnt_t'(1);
                                    code_d = RSP_ATK_HIT;
`ifdef SUNK_REPORT_EN
                                    rem_d[LW*int'(hit_id) +: LW] = hit_rem - len_t'(1);
                                    if (hit_rem == len_t'(1)) begin
                                        sunk_pulse_d = 1'b1;
                                        sunk_id_d    = hit_id;
                                    end
`endif
                                end
                                CELL_WATER: begin
                                    board_d[2*acc_idx +: 2] = CELL_MISS;
                                    code_d = RSP_ATK_MISS;
                                end
                                default: begin
                                    code_d = RSP_ATK_REPEAT;
                                end
                            endcase
                        end
                    end
                end
            end

            // One cell per cycle; the first occupied cell aborts the placement.
            S_CHECK: begin
                if (cur_cell != CELL_WATER) begin
                    code_d  = RSP_ERR_OVERLAP;
                    state_d = S_RESP;
                end else if (k_q == len_q - len_t'(1)) begin
                    k_d     = len_t'(0);
                    state_d = S_WRITE;
                end else begin
                    k_d = k_q + len_t'(1);
                end
            end

            S_WRITE: begin
                board_d[2*cur_idx +: 2] = CELL_SHIP;
`ifdef SUNK_REPORT_EN
                id_d[SW*cur_idx +: SW] = ships_q;
`endif
                if (k_q == len_q - len_t'(1)) begin
                    ships_d = ships_q + ship_t'(1);
                    left_d  = left_q + cnt_t'(len_q);
                    code_d  = RSP_PLACE_OK;
                    state_d = S_RESP;
`ifdef SUNK_REPORT_EN
                    rem_d[LW*int'(ships_q) +: LW] = len_q;
`endif
                end else begin
                    k_d = k_q + len_t'(1);
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Clear overrides any command on the same edge and drops the response.
        if (clr) begin
            state_d    = S_IDLE;
            row_d      = '0;
            col_d      = '0;
            len_d      = '0;
            vert_d     = 1'b0;
            k_d        = '0;
            code_d     = 3'd0;
            ships_d    = '0;
            left_d     = '0;
            sunk_all_d = 1'b0;
            board_d    = '0;
`ifdef SUNK_REPORT_EN
            id_d         = '0;
            rem_d        = '0;
            sunk_pulse_d = 1'b0;
            sunk_id_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            len_q      <= '0;
            vert_q     <= 1'b0;
            k_q        <= '0;
            code_q     <= 3'd0;
            ships_q    <= '0;
            left_q     <= '0;
            sunk_all_q <= 1'b0;
            board_q    <= '0;
`ifdef SUNK_REPORT_EN
            id_q         <= '0;
            rem_q        <= '0;
            sunk_pulse_q <= 1'b0;
            sunk_id_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            len_q      <= len_d;
            vert_q     <= vert_d;
            k_q        <= k_d;
            code_q     <= code_d;
            ships_q    <= ships_d;
            left_q     <= left_d;
            sunk_all_q <= sunk_all_d;
            board_q    <= board_d;
`ifdef SUNK_REPORT_EN
            id_q         <= id_d;
            rem_q        <= rem_d;
            sunk_pulse_q <= sunk_pulse_d;
            sunk_id_q    <= sunk_id_d;
`endif
        end
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign rsp_valid    = (state_q == S_RESP);
    assign rsp_code     = code_q;
    assign ships_placed = ships_q;
    assign cells_left   = left_q;
    assign all_sunk     = sunk_all_q;
`ifdef SUNK_REPORT_EN
    assign sunk_pulse = sunk_pulse_q;
    assign sunk_id    = sunk_id_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_battleship_board_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_battleship_board_ctrl
//  Purpose  : Directed and random bench for battleship_board_ctrl (default
//             parameters). The expected results come from a cell-array model
//             of the game rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_battleship_board_ctrl;

    localparam int N  = 5;
    localparam int MS = 4;
    localparam int ML = 3;
    localparam int CW = 3;
    localparam int LW = 2;
    localparam int SW = 3;
    localparam int KW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          lock = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_attack = 1'b0;
    logic          cmd_vert = 1'b0;
    logic [CW-1:0] cmd_row = '0;
    logic [CW-1:0] cmd_col = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [CW-1:0] rd_row = '0;
    logic [CW-1:0] rd_col = '0;
    logic          cmd_ready, rsp_valid, all_sunk;
    logic [2:0]    rsp_code;
    logic [SW-1:0] ships_placed;
    logic [KW-1:0] cells_left;
    logic [1:0]    rd_cell;
`ifdef SUNK_REPORT_EN
    logic          sunk_pulse;
    logic [SW-1:0] sunk_id;
`endif

    battleship_board_ctrl #(.BOARD_N(N), .MAX_SHIPS(MS), .MAX_LEN(ML)) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .lock         (lock),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_attack   (cmd_attack),
        .cmd_row      (cmd_row),
        .cmd_col      (cmd_col),
        .cmd_len      (cmd_len),
        .cmd_vert     (cmd_vert),
        .rsp_valid    (rsp_valid),
        .rsp_code     (rsp_code),
        .ships_placed (ships_placed),
        .cells_left   (cells_left),
        .all_sunk     (all_sunk),
`ifdef SUNK_REPORT_EN
        .sunk_pulse   (sunk_pulse),
        .sunk_id      (sunk_id),
`endif
        .rd_row       (rd_row),
        .rd_col       (rd_col),
        .rd_cell      (rd_cell)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain game state.
    int m_board [N][N];   // 0 water, 1 ship, 2 hit, 3 miss
    int m_id    [N][N];
    int m_rem   [MS];
    int m_ships, m_left, m_sinks;
    bit m_flag;
    bit m_exp_sp;
    int m_exp_sid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                m_board[r][c] = 0;
                m_id[r][c]    = 0;
            end
        for (int i = 0; i < MS; i++) m_rem[i] = 0;
        m_ships = 0;
        m_left  = 0;
        m_flag  = 1'b0;
    endtask

    // Applies one command to the model and returns the expected code and the
    // latency, counted in cycles from the accept edge to rsp_valid.
    task automatic model_cmd(input bit atk, input int r, input int c, input int len,
                             input bit vert, input bit lk, output int code, output int lat);
        int er, ec;
        m_exp_sp  = 1'b0;
        m_exp_sid = 0;
        lat = 1;
        if (!atk) begin
            er = vert ? r + len - 1 : r;
            ec = vert ? c : c + len - 1;
            if (lk) code = 7;
            else if (len == 0 || len > ML || r >= N || c >= N || er >= N || ec >= N) code = 1;
            else if (m_ships == MS) code = 3;
            else begin
                code = 0;
                for (int k = 0; k < len; k++) begin
                    if (m_board[vert ? r + k : r][vert ? c : c + k] != 0) begin
                        code = 2;
                        lat  = k + 2;
                        break;
                    end
                end
                if (code == 0) begin
                    for (int k = 0; k < len; k++) begin
                        m_board[vert ? r + k : r][vert ? c : c + k] = 1;
                        m_id[vert ? r + k : r][vert ? c : c + k]    = m_ships;
                    end
                    m_rem[m_ships] = len;
                    m_ships++;
                    m_left += len;
                    lat = 2 * len + 1;
                end
            end
        end else begin
            if (!lk) code = 7;
            else if (r >= N || c >= N) code = 1;
            else if (m_board[r][c] == 1) begin
                code = 5;
                m_board[r][c] = 2;
                m_left--;
                m_rem[m_id[r][c]]--;
                if (m_rem[m_id[r][c]] == 0) begin
                    m_exp_sp  = 1'b1;
                    m_exp_sid = m_id[r][c];
                    m_sinks++;
                end
            end else if (m_board[r][c] == 0) begin
                code = 4;
                m_board[r][c] = 3;
            end else code = 6;
        end
        m_flag = m_flag | (m_ships > 0 && m_left == 0);
    endtask

    task automatic do_cmd(input bit atk, input int r, input int c, input int len, input bit vert);
        int e_code, e_lat, lat;
        bit prev_flag, lk_acc;
        prev_flag = m_flag;
        lk_acc    = lock;
        model_cmd(atk, r, c, len, vert, lk_acc, e_code, e_lat);
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_attack = atk;
        cmd_row    = CW'(r);
        cmd_col    = CW'(c);
        cmd_len    = LW'(len);
        cmd_vert   = vert;
        tick();
        cmd_valid = 1'b0;
        // lock is sampled only at accept; wiggle it while the command runs.
        lock = 1'($urandom_range(0, 1));
        lat  = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            chk("ready_low_busy", cmd_ready, 0);
            tick();
            lat++;
        end
        chk("rsp_latency", lat, e_lat);
        chk("rsp_code", rsp_code, e_code);
        chk("ready_low_at_rsp", cmd_ready, 0);
        chk("all_sunk_at_rsp", all_sunk, prev_flag);
`ifdef SUNK_REPORT_EN
        chk("sunk_pulse", sunk_pulse, m_exp_sp);
        if (m_exp_sp) chk("sunk_id", sunk_id, m_exp_sid);
`endif
        tick();
        lock = lk_acc;
        chk("rsp_single_cycle", rsp_valid, 0);
        chk("ready_after_rsp", cmd_ready, 1);
        chk("ships_placed", ships_placed, m_ships);
        chk("cells_left", cells_left, m_left);
        chk("all_sunk", all_sunk, m_flag);
    endtask

    task automatic check_board(input string tag);
        int e;
        for (int r = 0; r < (1 << CW); r++)
            for (int c = 0; c < (1 << CW); c++) begin
                rd_row = CW'(r);
                rd_col = CW'(c);
                #1;
                e = (r < N && c < N) ? m_board[r][c] : 0;
                chk(tag, rd_cell, e);
            end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clr = 1'b0;
        cmd_valid = 1'b0;
        lock = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        tick();
        model_clear();
    endtask

    task automatic check_idle_empty(input string tag);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_code"}, rsp_code, 0);
        chk({tag, "_ships"}, ships_placed, 0);
        chk({tag, "_left"}, cells_left, 0);
        chk({tag, "_all_sunk"}, all_sunk, 0);
    endtask

    // Issues a len-3 horizontal place at (1,1) and returns after the first
    // WRITE edge has stored cell (1,1).
    task automatic start_place_into_write();
        cmd_valid  = 1'b1;
        cmd_attack = 1'b0;
        cmd_row    = 3'd1;
        cmd_col    = 3'd1;
        cmd_len    = 2'd3;
        cmd_vert   = 1'b0;
        tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        rd_row = 3'd1;
        rd_col = 3'd1;
        #1;
        chk("mid_write_cell", rd_cell, 2'b01);
    endtask

    task automatic check_no_rsp(input string tag);
        int seen = 0;
        repeat (10) begin
            tick();
            if (rsp_valid !== 1'b0) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        m_sinks = 0;
        model_clear();
        do_reset();
        check_idle_empty("reset");
        check_board("reset_board");

        // Placement, overlap, bounds and locked placement.
        do_cmd(0, 1, 1, 3, 0);
        check_board("after_place");
        do_cmd(0, 0, 2, 3, 1);
        do_cmd(0, 4, 3, 3, 0);
        lock = 1'b1;
        do_cmd(0, 4, 3, 3, 0);

        // Attack phase: sink ship 0, then repeat and miss.
        do_cmd(1, 1, 1, 0, 0);
        do_cmd(1, 1, 2, 0, 0);
        do_cmd(1, 1, 3, 0, 0);
        do_cmd(1, 1, 1, 0, 0);
        do_cmd(1, 0, 0, 0, 0);
        do_cmd(1, 5, 0, 0, 0);
        check_board("after_attacks");

        // Fill to MAX_SHIPS, then a fifth legal placement.
        do_reset();
        do_cmd(0, 1, 1, 3, 0);
        do_cmd(0, 3, 0, 1, 0);
        do_cmd(0, 4, 0, 2, 0);
        do_cmd(0, 0, 4, 3, 1);
        do_cmd(0, 2, 0, 1, 0);
        do_cmd(1, 2, 2, 0, 0);
        check_board("after_fill");

        // Synchronous clear while a ship is being written.
        do_reset();
        do_cmd(0, 3, 0, 2, 0);
        start_place_into_write();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_clear();
        check_idle_empty("clr");
        check_no_rsp("no_rsp_after_clr");
        check_board("clr_board");

        // Asynchronous reset while a ship is being written.
        do_cmd(0, 3, 0, 2, 0);
        start_place_into_write();
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_ships", ships_placed, 0);
        chk("async_rst_left", cells_left, 0);
        chk("async_rst_rsp", rsp_valid, 0);
        tick();
        #2;
        rst = 1'b1;
        tick();
        model_clear();
        check_idle_empty("rst");
        check_no_rsp("no_rsp_after_rst");
        check_board("rst_board");

        // Random placements, then random attacks.
        repeat (30) begin
            do_cmd(($urandom_range(0, 9) == 0), $urandom_range(0, 6), $urandom_range(0, 6),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        check_board("random_place_board");
        lock = 1'b1;
        repeat (60) begin
            do_cmd(($urandom_range(0, 7) != 0), $urandom_range(0, 5), $urandom_range(0, 5),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        check_board("random_attack_board");

        $display("model ships sunk: %0d", m_sinks);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
